// File: rtl/io_uart_if.sv
// io_uart_if: datapath IO bus seen by memory-mapped peripherals.
//   io_address     - byte address from the datapath
//   io_write_value - write data
//   io_read_value  - read data, driven combinationally by the selected peripheral
//   io_write_en    - write strobe
//   io_read_en     - read strobe
//   io_data_size   - access size (peripherals may ignore it)
// master: the datapath side; slave: the peripheral side.
interface io_uart_if;
  logic [31:0] io_address;
  logic [31:0] io_write_value;
  logic [31:0] io_read_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [2:0]  io_data_size;

  modport master (
    output io_address,
    output io_write_value,
    output io_write_en,
    output io_read_en,
    output io_data_size,
    input  io_read_value
  );

  modport slave (
    input  io_address,
    input  io_write_value,
    input  io_write_en,
    input  io_read_en,
    input  io_data_size,
    output io_read_value
  );
endinterface

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART peripheral.
// A TX FIFO feeds a serial shifter; an RX deserializer feeds an RX FIFO.
// Register window (16 bytes at BASE_ADDR, word index = io_address[3:2]):
//   0x0 TXDATA   W: push byte             R: 0
//   0x4 RXDATA   R: head byte (0 if empty), a strobed read pops it
//   0x8 STATUS   R: {frame_err, rx_overrun, rx_valid, tx_idle, tx_full}
//                W: 1 to bit3 / bit4 clears the sticky flag
//   0xC BAUD_DIV R/W [15:0], clk cycles per bit, 0 is stored as 1
// Ports:
//   clk     - system clock, all state on rising edge
//   rst_n   - asynchronous active-low reset
//   io      - datapath IO bus (slave side), reads are combinational
//   uart_rx - serial input, asynchronous to clk
//   uart_tx - serial output, idles high
//   rx_irq  - high while the RX FIFO holds data
module io_uart #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          TX_DEPTH    = 4,
  parameter int          RX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic      clk,
  input  logic      rst_n,
  io_uart_if.slave  io,
  input  logic      uart_rx,
  output logic      uart_tx,
  output logic      rx_irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // Mid-bit sample offset for the start bit, never zero so a DIV of 1 still works.
  function automatic logic [15:0] half_div(input logic [15:0] d);
    logic [15:0] h;
    h = d >> 1;
    return (h == 16'd0) ? 16'd1 : h;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       sel;
  logic [1:0] reg_idx;
  logic       wr_tx, rd_rx, wr_st, wr_bd;

  assign sel     = (io.io_address[31:4] == BASE_ADDR[31:4]);
  assign reg_idx = io.io_address[3:2];
  assign wr_tx   = sel && io.io_write_en && (reg_idx == 2'd0);
  assign rd_rx   = sel && io.io_read_en  && (reg_idx == 2'd1);
  assign wr_st   = sel && io.io_write_en && (reg_idx == 2'd2);
  assign wr_bd   = sel && io.io_write_en && (reg_idx == 2'd3);

  // Access size and the upper/lower address and data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{io.io_data_size, io.io_address[1:0], io.io_write_value[31:16]};

  // ---------------------------------------------------------------------------
  // Baud divisor and sticky flags
  // ---------------------------------------------------------------------------
  logic [15:0] baud_div;
  logic        flag_ovr, flag_ferr;
  logic        ovr_set, ferr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div  <= DEFAULT_DIV;
      flag_ovr  <= 1'b0;
      flag_ferr <= 1'b0;
    end else begin
      if (wr_bd)
        baud_div <= (io.io_write_value[15:0] == 16'd0) ? 16'd1 : io.io_write_value[15:0];
      // A new event in the same cycle as a clear keeps the flag set.
      flag_ovr  <= ovr_set  | (flag_ovr  & ~(wr_st & io.io_write_value[3]));
      flag_ferr <= ferr_set | (flag_ferr & ~(wr_st & io.io_write_value[4]));
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wptr, tx_rptr;
  logic           tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]     tx_head;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                    (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
  // Full is judged before this cycle's shifter pop, so a write into a full FIFO drops.
  assign tx_push  = wr_tx && !tx_full;
  assign tx_head  = tx_mem[tx_rptr[TX_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + (TX_AW+1)'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + (TX_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= io.io_write_value[7:0];
  end

  // ---------------------------------------------------------------------------
  // TX shifter
  // ---------------------------------------------------------------------------
  uart_state_t tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        tx_bnd, tx_idle;

  // Divisor is latched per bit so a BAUD_DIV write only lands on a bit boundary.
  assign tx_bnd  = (tx_cnt == tx_div - 16'd1);
  assign tx_idle = tx_empty && (tx_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_div   <= DEFAULT_DIV;
      tx_bit   <= 3'd0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh <= tx_sh_n;
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_head;
          tx_state_n = S_START;
          tx_cnt_n   = 16'd0;
          tx_bit_n   = 3'd0;
          tx_div_n   = baud_div;
        end
      end
      S_START: begin
        if (tx_bnd) begin
          tx_state_n = S_DATA;
          tx_cnt_n   = 16'd0;
          tx_bit_n   = 3'd0;
          tx_div_n   = baud_div;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_bnd) begin
          tx_cnt_n = 16'd0;
          tx_div_n = baud_div;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_state_n = S_STOP;
          else                tx_bit_n   = tx_bit + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_bnd) begin
          tx_cnt_n = 16'd0;
          tx_div_n = baud_div;
          // Chain straight into the next frame so queued bytes go out gap-free.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_head;
            tx_state_n = S_START;
            tx_bit_n   = 3'd0;
          end else begin
            tx_state_n = S_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // Line level decodes from reset-cleared state, so reset forces it high at once.
  always_comb begin
    case (tx_state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_sh[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX synchronizer
  // ---------------------------------------------------------------------------
  logic rx_meta, rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rs      <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // RX deserializer
  // ---------------------------------------------------------------------------
  uart_state_t rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rx_armed, rx_armed_n;
  logic        rx_push_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_div   <= DEFAULT_DIV;
      rx_bit   <= 3'd0;
      rx_armed <= 1'b1;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_armed <= rx_armed_n;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh <= rx_sh_n;
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_div_n    = rx_div;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_armed_n  = rx_armed;
    rx_push_req = 1'b0;
    ferr_set    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        // After a framing error the line must return high before a new start is accepted.
        if (rs) begin
          rx_armed_n = 1'b1;
        end else if (rx_armed) begin
          rx_state_n = S_START;
          rx_cnt_n   = 16'd0;
          rx_div_n   = baud_div;
        end
      end
      S_START: begin
        if (rx_cnt == half_div(rx_div)) begin
          rx_cnt_n   = 16'd0;
          rx_bit_n   = 3'd0;
          rx_div_n   = baud_div;
          rx_state_n = rs ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt == rx_div - 16'd1) begin
          rx_cnt_n = 16'd0;
          rx_div_n = baud_div;
          rx_sh_n  = {rs, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt == rx_div - 16'd1) begin
          rx_cnt_n   = 16'd0;
          rx_state_n = S_IDLE;
          if (rs) begin
            rx_push_req = 1'b1;
          end else begin
            ferr_set   = 1'b1;
            rx_armed_n = 1'b0;
          end
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wptr, rx_rptr;
  logic           rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]     rx_head;

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                    (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
  assign rx_pop   = rd_rx && !rx_empty;
  // A pop in the same cycle frees the slot, so push and pop both succeed on full.
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);
  assign ovr_set  = rx_push_req && rx_full && !rx_pop;
  assign rx_head  = rx_mem[rx_rptr[RX_AW-1:0]];
  assign rx_irq   = !rx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + (RX_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= rx_sh;
  end

  // ---------------------------------------------------------------------------
  // Combinational read-back
  // ---------------------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'd0;
    if (sel && io.io_read_en) begin
      case (reg_idx)
        2'd0:    rdata = 32'd0;
        2'd1:    rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
        2'd2:    rdata = {27'd0, flag_ferr, flag_ovr, !rx_empty, tx_idle, tx_full};
        default: rdata = {16'd0, baud_div};
      endcase
    end
  end

  assign io.io_read_value = rdata;

endmodule
